// File: rtl/quad_sample_packer_pkg.sv
// Shared constants and types for the sample packer and the top-2 selector.
package quad_sample_packer_pkg;

  localparam int DATA_W_DEF     = 4;
  localparam int DROP_CNT_W_DEF = 8;
  localparam int LANES          = 4;

  // Fill state: number of samples currently held in the assembly registers.
  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    FILL3 = 2'd3
  } fill_e;

endpackage

// File: rtl/packer_out_reg.sv
// Output holding register with valid/ready handshake; lane 0 is the oldest sample.
module packer_out_reg
  import quad_sample_packer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_i,
  input  logic [LANES-1:0][DATA_W-1:0] lanes_i,
  input  logic                         m_ready_i,
  output logic                         m_valid_o,
  output logic [LANES-1:0][DATA_W-1:0] lanes_o
);

  logic                         valid_q, valid_d;
  logic [LANES-1:0][DATA_W-1:0] lanes_q, lanes_d;

  // Load wins over consume so a same-cycle consume+complete keeps valid high.
  always_comb begin
    valid_d = valid_q;
    lanes_d = lanes_q;
    if (load_i) begin
      valid_d = 1'b1;
      lanes_d = lanes_i;
    end else if (valid_q && m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register; lanes keep their last value after consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      lanes_q <= '0;
    end else begin
      valid_q <= valid_d;
      lanes_q <= lanes_d;
    end
  end

  assign m_valid_o = valid_q;
  assign lanes_o   = lanes_q;

endmodule

// File: rtl/quad_sample_packer.sv
// Packs four consecutive serial samples into one parallel group, with
// start-of-frame resync and a saturating count of discarded partial groups.
module quad_sample_packer
  import quad_sample_packer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_sof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_a,
  output logic [DATA_W-1:0]     m_b,
  output logic [DATA_W-1:0]     m_c,
  output logic [DATA_W-1:0]     m_d,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  fill_e                        state_q, state_d;
  logic [LANES-2:0][DATA_W-1:0] asm_q, asm_d;
  logic [DROP_CNT_W-1:0]        drop_q, drop_d;
  logic                         accept, load;
  logic [LANES-1:0][DATA_W-1:0] grp_w, lanes_w;

  // Only the completing accept can stall; the sof term is deliberately ignored
  // so s_ready never depends on s_valid/s_data/s_sof.
  assign s_ready = (state_q != FILL3) || !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign load    = accept && !s_sof && (state_q == FILL3);
  assign grp_w   = {s_data, asm_q[2], asm_q[1], asm_q[0]};

  // Next-state for fill index, assembly regs and the drop counter.
  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    drop_d  = drop_q;
    if (accept) begin
      if (s_sof) begin
        asm_d[0] = s_data;
        state_d  = FILL1;
        if ((state_q != FILL0) && (drop_q != {DROP_CNT_W{1'b1}}))
          drop_d = drop_q + 1'b1;
      end else begin
        case (state_q)
          FILL0:   begin asm_d[0] = s_data; state_d = FILL1; end
          FILL1:   begin asm_d[1] = s_data; state_d = FILL2; end
          FILL2:   begin asm_d[2] = s_data; state_d = FILL3; end
          default: state_d = FILL0;
        endcase
      end
    end
  end

  // Fill state, assembly and drop-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL0;
      asm_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      drop_q  <= drop_d;
    end
  end

  packer_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .lanes_i  (grp_w),
    .m_ready_i(m_ready),
    .m_valid_o(m_valid),
    .lanes_o  (lanes_w)
  );

  assign m_a      = lanes_w[0];
  assign m_b      = lanes_w[1];
  assign m_c      = lanes_w[2];
  assign m_d      = lanes_w[3];
  assign drop_cnt = drop_q;

endmodule
